// File: rtl/pkt_classifier.sv
// Ingress classifier: buffers each frame's first two beats, chooses data, control or drop, and
// steers the whole frame to the matching registered output.
module pkt_classifier #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [15:0] CTRL_UDP_PORT        = 16'hf2f1,
    parameter int          DROP_NON_VLAN        = 1
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast,
    output logic [31:0]                       cnt_data_pkts,
    output logic [31:0]                       cnt_ctrl_pkts,
    output logic [31:0]                       cnt_drop_pkts
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD1  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] FLUSH  = 2'd3;

    localparam logic [1:0] CLS_DATA = 2'd0;
    localparam logic [1:0] CLS_CTRL = 2'd1;
    localparam logic [1:0] CLS_DROP = 2'd2;

    logic [1:0]                        state_r;
    logic [1:0]                        cls_r;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    hold_data_r;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   hold_user_r;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]  hold_keep_r;
    logic                              hold_last_r;

    logic [1:0] single_cls_s;
    logic [1:0] pair_cls_s;
    logic [1:0] emit_cls_s;
    logic       emit_s;

    // Single-beat frames pass two_beat = 0 so they can never become control.
    function automatic logic [1:0] classify(input logic [C_S_AXIS_DATA_WIDTH-1:0] b1,
                                            input logic [15:0] dport,
                                            input logic two_beat);
        logic tpid_ok;
        logic ipv4;
        logic udp;
        tpid_ok = (b1[96+:16] == 16'h0081);
        ipv4    = (b1[128+:16] == 16'h0008);
        udp     = (b1[216+:8] == 8'h11);
        if (two_beat && tpid_ok && ipv4 && udp && (dport == CTRL_UDP_PORT)) begin
            return CLS_CTRL;
        end else if (!tpid_ok && (DROP_NON_VLAN != 0)) begin
            return CLS_DROP;
        end else begin
            return CLS_DATA;
        end
    endfunction

    // Class candidates and the emit strobe for the beat sitting in the hold buffer.
    always_comb begin
        single_cls_s = classify(s_axis_tdata, 16'h0000, 1'b0);
        pair_cls_s   = classify(hold_data_r, s_axis_tdata[64+:16], 1'b1);
        emit_cls_s   = (state_r == HOLD1) ? pair_cls_s : cls_r;
        emit_s       = (state_r == FLUSH) ||
                       (s_axis_tvalid && ((state_r == HOLD1) || (state_r == STREAM)));
    end

    // Hold buffer, frame FSM and class register of the frame currently in the buffer.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r     <= IDLE;
            cls_r       <= CLS_DATA;
            hold_data_r <= '0;
            hold_user_r <= '0;
            hold_keep_r <= '0;
            hold_last_r <= 1'b0;
        end else begin
            if (s_axis_tvalid) begin
                hold_data_r <= s_axis_tdata;
                hold_user_r <= s_axis_tuser;
                hold_keep_r <= s_axis_tkeep;
                hold_last_r <= s_axis_tlast;
            end else begin
                hold_last_r <= hold_last_r;
            end
            case (state_r)
                IDLE, FLUSH: begin
                    // In FLUSH the old frame's last beat leaves this edge with the old cls_r,
                    // so a new frame's first beat can be taken without a bubble.
                    if (s_axis_tvalid && s_axis_tlast) begin
                        cls_r   <= single_cls_s;
                        state_r <= FLUSH;
                    end else if (s_axis_tvalid) begin
                        state_r <= HOLD1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                HOLD1: begin
                    if (s_axis_tvalid) begin
                        cls_r   <= pair_cls_s;
                        state_r <= s_axis_tlast ? FLUSH : STREAM;
                    end else begin
                        state_r <= HOLD1;
                    end
                end
                STREAM: begin
                    if (s_axis_tvalid) begin
                        state_r <= s_axis_tlast ? FLUSH : STREAM;
                    end else begin
                        state_r <= STREAM;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Registered output ports; dropped beats raise neither valid.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata    <= '0;
            m_axis_tuser    <= '0;
            m_axis_tkeep    <= '0;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
        end else begin
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
            if (emit_s) begin
                case (emit_cls_s)
                    CLS_DATA: begin
                        m_axis_tdata  <= hold_data_r;
                        m_axis_tuser  <= hold_user_r;
                        m_axis_tkeep  <= hold_keep_r;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= hold_last_r;
                    end
                    CLS_CTRL: begin
                        c_m_axis_tdata  <= hold_data_r;
                        c_m_axis_tuser  <= hold_user_r;
                        c_m_axis_tkeep  <= hold_keep_r;
                        c_m_axis_tvalid <= 1'b1;
                        c_m_axis_tlast  <= hold_last_r;
                    end
                    default: begin
                        m_axis_tvalid <= 1'b0;
                    end
                endcase
            end else begin
                c_m_axis_tvalid <= 1'b0;
            end
        end
    end

    // Frame counters step when the frame's last beat is (or would have been) emitted.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_data_pkts <= 32'd0;
            cnt_ctrl_pkts <= 32'd0;
            cnt_drop_pkts <= 32'd0;
        end else if (emit_s && hold_last_r) begin
            case (emit_cls_s)
                CLS_DATA: cnt_data_pkts <= cnt_data_pkts + 32'd1;
                CLS_CTRL: cnt_ctrl_pkts <= cnt_ctrl_pkts + 32'd1;
                default:  cnt_drop_pkts <= cnt_drop_pkts + 32'd1;
            endcase
        end else begin
            cnt_data_pkts <= cnt_data_pkts;
        end
    end

endmodule

// File: tb/tb_pkt_classifier.sv
// Directed bench for pkt_classifier: one instance drops non-VLAN frames, a second forwards them.
module tb_pkt_classifier;

    typedef logic [416:0] ent_t;

    logic         clk = 1'b0;
    logic         aresetn;
    logic [255:0] s_tdata;
    logic [127:0] s_tuser;
    logic [31:0]  s_tkeep;
    logic         s_tvalid;
    logic         s_tlast;

    logic [255:0] m_tdata, c_tdata, m1_tdata, c1_tdata;
    logic [127:0] m_tuser, c_tuser, m1_tuser, c1_tuser;
    logic [31:0]  m_tkeep, c_tkeep, m1_tkeep, c1_tkeep;
    logic         m_tvalid, m_tlast, c_tvalid, c_tlast;
    logic         m1_tvalid, m1_tlast, c1_tvalid, c1_tlast;
    logic [31:0]  cnt_data, cnt_ctrl, cnt_drop, cnt1_data, cnt1_ctrl, cnt1_drop;

    int   errors = 0;
    int   checks = 0;
    int   excl_viol = 0;
    ent_t m_q[$];
    ent_t c_q[$];
    ent_t m1_q[$];
    ent_t exp_q[$];

    always #5 clk = ~clk;

    pkt_classifier dut (
        .axis_clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tkeep(s_tkeep),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tkeep(m_tkeep),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .c_m_axis_tdata(c_tdata), .c_m_axis_tuser(c_tuser), .c_m_axis_tkeep(c_tkeep),
        .c_m_axis_tvalid(c_tvalid), .c_m_axis_tlast(c_tlast),
        .cnt_data_pkts(cnt_data), .cnt_ctrl_pkts(cnt_ctrl), .cnt_drop_pkts(cnt_drop)
    );

    pkt_classifier #(.DROP_NON_VLAN(0)) dut_keep (
        .axis_clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tkeep(s_tkeep),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m1_tdata), .m_axis_tuser(m1_tuser), .m_axis_tkeep(m1_tkeep),
        .m_axis_tvalid(m1_tvalid), .m_axis_tlast(m1_tlast),
        .c_m_axis_tdata(c1_tdata), .c_m_axis_tuser(c1_tuser), .c_m_axis_tkeep(c1_tkeep),
        .c_m_axis_tvalid(c1_tvalid), .c_m_axis_tlast(c1_tlast),
        .cnt_data_pkts(cnt1_data), .cnt_ctrl_pkts(cnt1_ctrl), .cnt_drop_pkts(cnt1_drop)
    );

    // Capture every emitted beat on the clock's falling edge, away from the update edge.
    always @(negedge clk) begin
        if (m_tvalid) m_q.push_back({m_tlast, m_tkeep, m_tuser, m_tdata});
        if (c_tvalid) c_q.push_back({c_tlast, c_tkeep, c_tuser, c_tdata});
        if (m1_tvalid) m1_q.push_back({m1_tlast, m1_tkeep, m1_tuser, m1_tdata});
        if ((m_tvalid && c_tvalid) || (m1_tvalid && c1_tvalid)) excl_viol++;
    end

    function automatic logic [255:0] pat(input logic [7:0] tag);
        return {8{tag, 24'hc3a55a}};
    endfunction

    function automatic logic [255:0] hdr(input logic [15:0] tpid, input logic [15:0] etype,
                                         input logic [7:0] proto, input logic [7:0] tag);
        logic [255:0] d;
        d = pat(tag);
        d[96+:16]  = tpid;
        d[128+:16] = etype;
        d[216+:8]  = proto;
        return d;
    endfunction

    function automatic logic [255:0] port(input logic [15:0] dport, input logic [7:0] tag);
        logic [255:0] d;
        d = pat(tag);
        d[64+:16] = dport;
        return d;
    endfunction

    function automatic logic [31:0] keep_of(input logic l);
        return l ? 32'h0000_ffff : 32'hffff_ffff;
    endfunction

    function automatic ent_t mk(input logic [255:0] d, input logic l);
        return {l, keep_of(l), d[255:128], d};
    endfunction

    task automatic chk(input string tag, input logic [419:0] obs, input logic [419:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input ent_t got[$], input ent_t exp[$]);
        chk({tag, "_count"}, 420'(got.size()), 420'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) chk($sformatf("%s_beat%0d", tag, i), 420'(got[i]), 420'(exp[i]));
        end
    endtask

    task automatic drive(input logic [255:0] d, input logic l);
        s_tdata  = d;
        s_tuser  = d[255:128];
        s_tkeep  = keep_of(l);
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_qs();
        m_q.delete();
        c_q.delete();
        m1_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_m"}, 420'({m_tvalid, m_tlast, m_tkeep, m_tuser, m_tdata}), 420'd0);
        chk({tag, "_c"}, 420'({c_tvalid, c_tlast, c_tkeep, c_tuser, c_tdata}), 420'd0);
        chk({tag, "_cnt"}, 420'({cnt_data, cnt_ctrl, cnt_drop}), 420'd0);
    endtask

    initial begin
        logic [255:0] b1, b2, b3, b4, b5, b6;
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 256'd0;
        s_tuser  = 128'd0;
        s_tkeep  = 32'd0;
        #12;
        check_zero_outputs("reset");
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        // Single-beat VLAN frame goes to data with tlast.
        clear_qs();
        b1 = hdr(16'h0081, 16'h0008, 8'h11, 8'h01);
        drive(b1, 1'b1);
        gap(3);
        exp_q.push_back(mk(b1, 1'b1));
        check_q("single_m", m_q, exp_q);
        chk("single_c_none", 420'(c_q.size()), 420'd0);
        chk("single_cnt", 420'({cnt_data, cnt_ctrl, cnt_drop}), 420'({32'd1, 32'd0, 32'd0}));

        // Three-beat control frame.
        clear_qs();
        b1 = hdr(16'h0081, 16'h0008, 8'h11, 8'h02);
        b2 = port(16'hf2f1, 8'h03);
        b3 = pat(8'h04);
        drive(b1, 1'b0);
        drive(b2, 1'b0);
        drive(b3, 1'b1);
        gap(4);
        exp_q = '{mk(b1, 1'b0), mk(b2, 1'b0), mk(b3, 1'b1)};
        check_q("ctrl_c", c_q, exp_q);
        chk("ctrl_m_none", 420'(m_q.size()), 420'd0);
        chk("ctrl_cnt", 420'({cnt_data, cnt_ctrl, cnt_drop}), 420'({32'd1, 32'd1, 32'd0}));

        // Same header with a non-control port and two-cycle gaps.
        clear_qs();
        b1 = hdr(16'h0081, 16'h0008, 8'h11, 8'h05);
        b2 = port(16'h1234, 8'h06);
        b3 = pat(8'h07);
        drive(b1, 1'b0);
        gap(2);
        drive(b2, 1'b0);
        gap(2);
        drive(b3, 1'b1);
        gap(4);
        exp_q = '{mk(b1, 1'b0), mk(b2, 1'b0), mk(b3, 1'b1)};
        check_q("gap_m", m_q, exp_q);
        chk("gap_c_none", 420'(c_q.size()), 420'd0);
        chk("gap_cnt", 420'({cnt_data, cnt_ctrl, cnt_drop}), 420'({32'd2, 32'd1, 32'd0}));

        // Non-VLAN frame: dropped by the default instance, forwarded by the other.
        clear_qs();
        b1 = hdr(16'h0008, 16'h0008, 8'h11, 8'h08);
        b2 = port(16'hf2f1, 8'h09);
        drive(b1, 1'b0);
        drive(b2, 1'b1);
        gap(4);
        chk("drop_m_none", 420'(m_q.size()), 420'd0);
        chk("drop_c_none", 420'(c_q.size()), 420'd0);
        chk("drop_cnt", 420'({cnt_data, cnt_ctrl, cnt_drop}), 420'({32'd2, 32'd1, 32'd1}));
        exp_q = '{mk(b1, 1'b0), mk(b2, 1'b1)};
        check_q("keep_m", m1_q, exp_q);

        // Back-to-back control frame then four-beat data frame, tvalid held high.
        clear_qs();
        b1 = hdr(16'h0081, 16'h0008, 8'h11, 8'h0a);
        b2 = port(16'hf2f1, 8'h0b);
        b3 = hdr(16'h0081, 16'h0008, 8'h11, 8'h0c);
        b4 = port(16'h1234, 8'h0d);
        b5 = pat(8'h0e);
        b6 = pat(8'h0f);
        drive(b1, 1'b0);
        drive(b2, 1'b1);
        drive(b3, 1'b0);
        drive(b4, 1'b0);
        drive(b5, 1'b0);
        drive(b6, 1'b1);
        gap(4);
        exp_q = '{mk(b1, 1'b0), mk(b2, 1'b1)};
        check_q("b2b_c", c_q, exp_q);
        exp_q = '{mk(b3, 1'b0), mk(b4, 1'b0), mk(b5, 1'b0), mk(b6, 1'b1)};
        check_q("b2b_m", m_q, exp_q);
        chk("b2b_cnt", 420'({cnt_data, cnt_ctrl, cnt_drop}), 420'({32'd3, 32'd2, 32'd1}));
        chk("keep_cnt", 420'({cnt1_data, cnt1_ctrl, cnt1_drop}), 420'({32'd4, 32'd2, 32'd0}));
        chk("one_hot_valid", 420'(excl_viol), 420'd0);

        // Asynchronous reset during beat 2 of a four-beat frame.
        b1 = hdr(16'h0081, 16'h0008, 8'h11, 8'h10);
        b2 = port(16'h1234, 8'h11);
        drive(b1, 1'b0);
        drive(b2, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        clear_qs();
        b1 = hdr(16'h0081, 16'h0008, 8'h11, 8'h12);
        b2 = port(16'hf2f1, 8'h13);
        drive(b1, 1'b0);
        drive(b2, 1'b1);
        gap(4);
        exp_q = '{mk(b1, 1'b0), mk(b2, 1'b1)};
        check_q("post_rst_c", c_q, exp_q);
        chk("post_rst_m_none", 420'(m_q.size()), 420'd0);
        chk("post_rst_cnt", 420'({cnt_data, cnt_ctrl, cnt_drop}), 420'({32'd0, 32'd1, 32'd0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
